hazard_ctrl: RTL and testbench

- Pipeline sequencer for the 5-stage core; sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Each cycle, decides every stage-register enable and flush from EX/MEM stage status:
  - load-use stalls;
  - taken-branch squashes;
  - multi-cycle data-memory freezes;
  - halt drain and restart.
- Keeps a saturating stall-cycle counter for performance debug.

---
 rtl/core_pkg.sv | 20 ++
 rtl/hazard_ctrl_mem_freeze_cnt.sv | 38 +++
 rtl/hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the pipeline sequencer: sequencer states,
// register-address width and the source/destination compare helper.
package core_pkg;

  localparam int REG_AW = 3;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  // True when an ID source operand is actually read and names the EX destination.
  function automatic logic src_hit(input logic              uses,
                                   input logic [REG_AW-1:0] src,
                                   input logic [REG_AW-1:0] dst);
    return uses && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_ctrl_mem_freeze_cnt.sv
// Data-memory freeze counter. It keeps a memory instruction in MEM for
// exactly MEM_LAT cycles by freezing the whole pipeline for MEM_LAT-1 of them.
module mem_freeze_cnt #(
  parameter int MEM_LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic mem_req_mem,
  output logic freeze
);

  localparam logic       LAT_MULTI = (MEM_LAT > 1);
  localparam logic [3:0] LOAD_VAL  = (MEM_LAT > 1) ? 4'(MEM_LAT - 2) : 4'd0;

  logic [3:0] mcnt;
  logic       mwait;
  logic       start;

  // A new access starts a freeze unless the current one has already been served.
  assign start  = mem_req_mem & ~mwait & LAT_MULTI & (mcnt == 4'd0);
  assign freeze = (mcnt != 4'd0) | (mem_req_mem & ~mwait & LAT_MULTI);

  // Count down the remaining frozen cycles; mwait marks the access as served
  // until the first unfrozen cycle so a back-to-back access gets its own freeze.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcnt  <= 4'd0;
      mwait <= 1'b0;
    end else if (start) begin
      mcnt  <= LOAD_VAL;
      mwait <= 1'b1;
    end else begin
      if (mcnt != 4'd0) mcnt <= mcnt - 4'd1;
      if (!freeze) mwait <= 1'b0;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core. Drives the stage-register enables
// and flushes for load-use stalls, taken branches, memory freezes and halt.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int MEM_LAT   = 2,
  parameter int DRAIN_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] ra_adr_id,
  input  logic [REG_AW-1:0] rb_adr_id,
  input  logic              uses_ra_id,
  input  logic              uses_rb_id,
  input  logic              regwrite_ex,
  input  logic              from_main_mem_ex,
  input  logic [REG_AW-1:0] regwrite_adr_ex,
  input  logic              branch_taken_ex,
  input  logic              is_halt_ex,
  input  logic              mem_req_mem,
  input  logic              restart,
  output logic              en_pc,
  output logic              en_ifid,
  output logic              en_idex,
  output logic              en_exmem,
  output logic              en_memwb,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic              halted,
  output logic [15:0]       stall_cnt
);

  localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYC);

  state_t     state;
  logic [7:0] dcnt;
  logic       freeze;
  logic       load_use;

  mem_freeze_cnt #(
    .MEM_LAT(MEM_LAT)
  ) u_freeze (
    .clk        (clk),
    .reset      (reset),
    .mem_req_mem(mem_req_mem),
    .freeze     (freeze)
  );

  assign load_use = from_main_mem_ex & regwrite_ex &
                    (src_hit(uses_ra_id, ra_adr_id, regwrite_adr_ex) |
                     src_hit(uses_rb_id, rb_adr_id, regwrite_adr_ex));

  // Stage control: reset forces bubbles everywhere, a freeze stops everything,
  // otherwise the state and the EX/MEM hazards pick the enables and flushes.
  always_comb begin
    en_pc      = 1'b0;
    en_ifid    = 1'b0;
    en_idex    = 1'b0;
    en_exmem   = 1'b0;
    en_memwb   = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    halted     = 1'b0;
    if (!reset) begin
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end else begin
      halted = (state == HALTED);
      if (!freeze) begin
        case (state)
          RUN: begin
            en_pc    = 1'b1;
            en_ifid  = 1'b1;
            en_idex  = 1'b1;
            en_exmem = 1'b1;
            en_memwb = 1'b1;
            if (is_halt_ex) begin
              en_pc      = 1'b0;
              flush_ifid = 1'b1;
              flush_idex = 1'b1;
            end else if (branch_taken_ex) begin
              flush_ifid = 1'b1;
              flush_idex = 1'b1;
            end else if (load_use) begin
              en_pc      = 1'b0;
              en_ifid    = 1'b0;
              flush_idex = 1'b1;
            end
          end
          DRAIN: begin
            en_exmem   = 1'b1;
            en_memwb   = 1'b1;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
          end
          HALTED: begin
            if (restart) begin
              flush_ifid = 1'b1;
              flush_idex = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Sequencer state, drain countdown and the saturating stall counter. DRAIN
  // lasts exactly DRAIN_CYC unfrozen cycles (at least one), so the exit is
  // taken on the cycle that exhausts the count. Every RUN cycle that holds
  // the PC counts as a stall, including the halt-detection cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      dcnt      <= 8'd0;
      stall_cnt <= 16'd0;
    end else begin
      if ((state == RUN) && !en_pc && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
      if (!freeze) begin
        case (state)
          RUN: begin
            if (is_halt_ex) begin
              state <= DRAIN;
              dcnt  <= DRAIN_LOAD;
            end
          end
          DRAIN: begin
            if (dcnt <= 8'd1) begin
              state <= HALTED;
              dcnt  <= 8'd0;
            end else begin
              dcnt <= dcnt - 8'd1;
            end
          end
          HALTED: begin
            if (restart) state <= RUN;
          end
          default: state <= RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_hazard_ctrl;

  localparam int MEM_LAT   = 3;
  localparam int DRAIN_CYC = 2;
  localparam int DRAIN_MIN = (DRAIN_CYC < 1) ? 1 : DRAIN_CYC;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] ra_adr_id = '0, rb_adr_id = '0, regwrite_adr_ex = '0;
  logic       uses_ra_id = 0, uses_rb_id = 0, regwrite_ex = 0, from_main_mem_ex = 0;
  logic       branch_taken_ex = 0, is_halt_ex = 0, mem_req_mem = 0, restart = 0;
  logic       en_pc, en_ifid, en_idex, en_exmem, en_memwb;
  logic       flush_ifid, flush_idex, halted;
  logic [15:0] stall_cnt;
  logic [7:0]  act_vec;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .MEM_LAT  (MEM_LAT),
    .DRAIN_CYC(DRAIN_CYC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .ra_adr_id       (ra_adr_id),
    .rb_adr_id       (rb_adr_id),
    .uses_ra_id      (uses_ra_id),
    .uses_rb_id      (uses_rb_id),
    .regwrite_ex     (regwrite_ex),
    .from_main_mem_ex(from_main_mem_ex),
    .regwrite_adr_ex (regwrite_adr_ex),
    .branch_taken_ex (branch_taken_ex),
    .is_halt_ex      (is_halt_ex),
    .mem_req_mem     (mem_req_mem),
    .restart         (restart),
    .en_pc           (en_pc),
    .en_ifid         (en_ifid),
    .en_idex         (en_idex),
    .en_exmem        (en_exmem),
    .en_memwb        (en_memwb),
    .flush_ifid      (flush_ifid),
    .flush_idex      (flush_idex),
    .halted          (halted),
    .stall_cnt       (stall_cnt)
  );

  // Output vector layout: {en_pc, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, flush_idex, halted}
  assign act_vec = {en_pc, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, flush_idex, halted};

  // Behavioural model: whether the core is stopped or draining, how many
  // unfrozen drain cycles have elapsed, and how old the current memory access is.
  bit         m_stopped, m_draining, m_in_op;
  int         m_drain_done, m_op_age, m_stalls;
  logic [7:0] exp_vec;
  bit         exp_freeze;
  bit         exp_lu;

  task modelReset;
    m_stopped    = 0;
    m_draining   = 0;
    m_in_op      = 0;
    m_drain_done = 0;
    m_op_age     = 0;
    m_stalls     = 0;
  endtask

  task modelEval;
    exp_freeze = m_in_op ? (m_op_age < MEM_LAT - 1) : (mem_req_mem && (MEM_LAT > 1));
    exp_lu = from_main_mem_ex && regwrite_ex &&
             ((uses_ra_id && ra_adr_id == regwrite_adr_ex) ||
              (uses_rb_id && rb_adr_id == regwrite_adr_ex));
    if (!reset)               exp_vec = 8'h06;
    else if (exp_freeze)      exp_vec = {7'b0, m_stopped};
    else if (m_stopped)       exp_vec = restart ? 8'h07 : 8'h01;
    else if (m_draining)      exp_vec = 8'h1E;
    else if (is_halt_ex)      exp_vec = 8'h7E;
    else if (branch_taken_ex) exp_vec = 8'hFE;
    else if (exp_lu)          exp_vec = 8'h3A;
    else                      exp_vec = 8'hF8;
  endtask

  task modelStep;
    if (!reset) begin
      modelReset();
      return;
    end
    if (!m_stopped && !m_draining && !exp_vec[7] && m_stalls < 65535)
      m_stalls++;
    if (m_in_op) begin
      if (m_op_age >= MEM_LAT - 1) m_in_op = 0;
      else m_op_age++;
    end else if (mem_req_mem && (MEM_LAT > 1)) begin
      m_in_op  = 1;
      m_op_age = 1;
    end
    if (!exp_freeze) begin
      if (m_stopped) begin
        if (restart) m_stopped = 0;
      end else if (m_draining) begin
        m_drain_done++;
        if (m_drain_done >= DRAIN_MIN) begin
          m_draining = 0;
          m_stopped  = 1;
        end
      end else if (is_halt_ex) begin
        m_draining   = 1;
        m_drain_done = 0;
      end
    end
  endtask

  task cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task checkOutput;
    if (!reset) modelReset();
    modelEval();
    cmp("outputs", {8'h00, act_vec}, {8'h00, exp_vec});
    cmp("stall_cnt", stall_cnt, 16'(m_stalls));
  endtask

  task applyStimulus(input logic fm, input logic rw, input logic [2:0] wa,
                     input logic ura, input logic [2:0] ra,
                     input logic urb, input logic [2:0] rb,
                     input logic br, input logic hlt, input logic mreq,
                     input logic rs, input logic rst_val);
    from_main_mem_ex = fm;
    regwrite_ex      = rw;
    regwrite_adr_ex  = wa;
    uses_ra_id       = ura;
    ra_adr_id        = ra;
    uses_rb_id       = urb;
    rb_adr_id        = rb;
    branch_taken_ex  = br;
    is_halt_ex       = hlt;
    mem_req_mem      = mreq;
    restart          = rs;
    reset            = rst_val;
  endtask

  task idle;
    applyStimulus(0, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 0, 1);
  endtask

  task checkPhase;
    #1;
    checkOutput();
  endtask

  task advance;
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  initial begin
    logic keep_mem;
    modelReset();
    keep_mem = 0;
    @(negedge clk);

    // Reset held low: bubbles everywhere, counter cleared.
    checkPhase();
    cmp("reset_vec", {8'h00, act_vec}, 16'h0006);
    cmp("reset_stall", stall_cnt, 16'd0);
    advance();

    idle();
    checkPhase();
    cmp("run_idle", {8'h00, act_vec}, 16'h00F8);
    advance();

    // Load r3 in EX, ID reads r3 through rb: one bubble.
    applyStimulus(1, 1, 3'd3, 0, 3'd0, 1, 3'd3, 0, 0, 0, 0, 1);
    checkPhase();
    cmp("loaduse_vec", {8'h00, act_vec}, 16'h003A);
    advance();
    cmp("loaduse_stall", stall_cnt, 16'd1);
    idle();
    checkPhase();
    cmp("after_loaduse", {8'h00, act_vec}, 16'h00F8);
    advance();

    // ra names r3 but is not read: no stall.
    applyStimulus(1, 1, 3'd3, 0, 3'd3, 0, 3'd0, 0, 0, 0, 0, 1);
    checkPhase();
    cmp("unused_src", {8'h00, act_vec}, 16'h00F8);
    advance();

    // Taken branch squashes two slots, PC loads target.
    applyStimulus(0, 0, 3'd0, 0, 3'd0, 0, 3'd0, 1, 0, 0, 0, 1);
    checkPhase();
    cmp("branch_vec", {8'h00, act_vec}, 16'h00FE);
    advance();
    cmp("branch_stall", stall_cnt, 16'd1);

    // Two back-to-back memory accesses, each frozen for MEM_LAT-1 cycles.
    for (int op = 0; op < 2; op++) begin
      for (int c = 0; c < MEM_LAT; c++) begin
        applyStimulus(0, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 1, 0, 1);
        checkPhase();
        cmp("mem_freeze", {8'h00, act_vec}, (c < MEM_LAT - 1) ? 16'h0000 : 16'h00F8);
        advance();
      end
    end
    cmp("mem_stall", stall_cnt, 16'd5);

    // Halt together with branch: halt wins, then drain, halt, restart.
    applyStimulus(0, 0, 3'd0, 0, 3'd0, 0, 3'd0, 1, 1, 0, 0, 1);
    checkPhase();
    cmp("halt_vec", {8'h00, act_vec}, 16'h007E);
    advance();
    cmp("halt_stall", stall_cnt, 16'd6);
    applyStimulus(0, 0, 3'd0, 0, 3'd0, 0, 3'd0, 1, 1, 0, 1, 1);
    checkPhase();
    cmp("drain1", {8'h00, act_vec}, 16'h001E);
    advance();
    idle();
    checkPhase();
    cmp("drain2", {8'h00, act_vec}, 16'h001E);
    advance();
    checkPhase();
    cmp("halted", {8'h00, act_vec}, 16'h0001);
    advance();
    applyStimulus(0, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 1, 1);
    checkPhase();
    cmp("restart_vec", {8'h00, act_vec}, 16'h0007);
    advance();
    idle();
    checkPhase();
    cmp("resumed", {8'h00, act_vec}, 16'h00F8);
    cmp("resumed_stall", stall_cnt, 16'd6);
    advance();

    // Reset asserted in the middle of a freeze.
    applyStimulus(0, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 1, 0, 1);
    checkPhase();
    advance();
    applyStimulus(0, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 0, 1);
    #2;
    reset = 1'b0;
    checkPhase();
    cmp("midreset_vec", {8'h00, act_vec}, 16'h0006);
    cmp("midreset_stall", stall_cnt, 16'd0);
    advance();
    idle();
    checkPhase();
    cmp("post_reset", {8'h00, act_vec}, 16'h00F8);
    advance();

    // Randomized traffic checked every cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      keep_mem = mem_req_mem ? ($urandom_range(99) < 70) : ($urandom_range(99) < 25);
      applyStimulus($urandom_range(99) < 40, $urandom_range(99) < 60, 3'($urandom_range(3)),
                    $urandom_range(1) == 1, 3'($urandom_range(3)),
                    $urandom_range(1) == 1, 3'($urandom_range(3)),
                    $urandom_range(99) < 10, $urandom_range(99) < 4, keep_mem,
                    $urandom_range(99) < 15, $urandom_range(499) != 0);
      checkPhase();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
